bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single system bus between up to NUM_MASTERS bus masters (UART test master, DMA-style movers, debug masters).
- Each master raises a request. The arbiter grants exactly one master, enforces a maximum tenancy, and never revokes a grant while a slave transaction is in flight.
- It sits between the master-side BIUs and the shared bus; a granted master's BIU is the only one allowed to drive the bus.

---
 rtl/bus_arb_pkg.sv | 33 +++
 rtl/bus_arbiter_rr_picker.sv | 41 ++++
 rtl/bus_arbiter.sv | 133 +++++++++++++
 tb/tb_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared types and helpers for the round-robin bus arbiter:
//                FSM state encoding, width helpers and pointer wrap function.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    // FSM states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of an index into n requesters (never less than one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must reach max_hold-1
    function automatic int cnt_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

    // Next round-robin position; explicit compare so non-power-of-2 counts wrap correctly
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin winner selection. The winner is
//                the requester at the smallest wrapped distance from i_rr_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic [IDX_W-1:0]       o_winner,
    output logic                   o_any_req
);

    int w_best;
    int w_dist;

    // Scan all requesters, keep the one closest to the pointer going upward with wrap
    always_comb begin
        w_best    = NUM_MASTERS;
        w_dist    = 0;
        o_winner  = '0;
        o_any_req = |i_req;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (i >= int'(i_rr_ptr)) begin
                w_dist = i - int'(i_rr_ptr);
            end else begin
                w_dist = i + NUM_MASTERS - int'(i_rr_ptr);
            end
            if (i_req[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_winner = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin shared-bus arbiter with tenancy timeout, lock
//                override and drain of in-flight slave transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 4,
    parameter int MAX_HOLD_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         i_req,
    input  logic [NUM_MASTERS-1:0]         i_lock,
    input  logic                           i_bus_busy,
    output logic [NUM_MASTERS-1:0]         o_gnt,
    output logic [$clog2(NUM_MASTERS)-1:0] o_gnt_idx,
    output logic                           o_gnt_valid,
    output logic                           o_revoke,
    output logic                           o_timeout
);

    localparam int c_IDX_W = idx_width(NUM_MASTERS);
    localparam int c_CNT_W = cnt_width(MAX_HOLD_CYCLES);
    localparam logic [c_CNT_W-1:0]     c_HOLD_MAX = c_CNT_W'(MAX_HOLD_CYCLES - 1);
    localparam logic [NUM_MASTERS-1:0] c_ONE      = NUM_MASTERS'(1);

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_hold_cnt;
    logic [c_IDX_W-1:0]     r_rr_ptr;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [c_IDX_W-1:0]     r_gnt_idx;
    logic                   r_gnt_valid;
    logic                   r_revoke;
    logic                   r_timeout;

    logic [c_IDX_W-1:0]     w_winner;
    logic                   w_any_req;
    logic                   w_own_req;
    logic                   w_own_lock;
    logic                   w_hold_sat;
    logic                   w_rel_drop;
    logic                   w_rel_tmo;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_picker (
        .i_req     (i_req),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    // Release causes for the current owner; a dropped request takes priority over timeout
    assign w_own_req  = i_req[r_gnt_idx];
    assign w_own_lock = i_lock[r_gnt_idx];
    assign w_hold_sat = (r_hold_cnt == c_HOLD_MAX);
    assign w_rel_drop = ~w_own_req;
    assign w_rel_tmo  = w_hold_sat & w_own_req & ~w_own_lock;

    // Arbitration FSM with registered grant, revoke and timeout outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_revoke    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_gnt       <= c_ONE << w_winner;
                        r_gnt_idx   <= w_winner;
                        r_gnt_valid <= 1'b1;
                        r_rr_ptr    <= c_IDX_W'(rr_next(int'(w_winner), NUM_MASTERS));
                        r_hold_cnt  <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_rel_drop || w_rel_tmo) begin
                        r_timeout <= w_rel_tmo;
                        if (i_bus_busy) begin
                            // Keep the grant until the slave transaction completes
                            r_revoke <= 1'b1;
                            r_state  <= DRAIN;
                        end else begin
                            r_gnt       <= '0;
                            r_gnt_idx   <= '0;
                            r_gnt_valid <= 1'b0;
                            r_state     <= IDLE;
                        end
                    end else if (!w_hold_sat) begin
                        r_hold_cnt <= r_hold_cnt + c_CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (!i_bus_busy) begin
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_valid <= 1'b0;
                        r_revoke    <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_gnt       <= '0;
                    r_gnt_idx   <= '0;
                    r_gnt_valid <= 1'b0;
                    r_revoke    <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_gnt_idx;
    assign o_gnt_valid = r_gnt_valid;
    assign o_revoke    = r_revoke;
    assign o_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter (3 masters, hold limit 8)
//                with an owner/tenure reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N    = 3;
    localparam int MAXH = 8;
    localparam int IW   = 2;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic [N-1:0]  req  = '0;
    logic [N-1:0]  lock = '0;
    logic          busy = 1'b0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gidx;
    logic          gvalid;
    logic          revoke;
    logic          tmo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS     (N),
        .MAX_HOLD_CYCLES (MAXH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_lock      (lock),
        .i_bus_busy  (busy),
        .o_gnt       (gnt),
        .o_gnt_idx   (gidx),
        .o_gnt_valid (gvalid),
        .o_revoke    (revoke),
        .o_timeout   (tmo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic bitof(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Reference model: who owns the bus, for how many cycles, and whether it is draining
    int owner  = -1;
    bit drain  = 1'b0;
    int ptr    = 0;
    int tenure = 0;
    bit m_tmo  = 1'b0;
    bit m_live = 1'b0;

    always @(posedge clk) begin
        bit dropped;
        bit expired;
        m_tmo = 1'b0;
        if (rst) begin
            owner  = -1;
            drain  = 1'b0;
            ptr    = 0;
            tenure = 0;
            m_live = 1'b1;
        end else if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (owner < 0 && bitof(req, (ptr + k) % N)) owner = (ptr + k) % N;
            end
            if (owner >= 0) begin
                ptr    = (owner + 1) % N;
                tenure = 1;
            end
        end else if (drain) begin
            if (!busy) begin
                owner = -1;
                drain = 1'b0;
            end
        end else begin
            dropped = !bitof(req, owner);
            expired = (tenure >= MAXH) && !dropped && !bitof(lock, owner);
            if (dropped || expired) begin
                m_tmo = expired;
                if (busy) drain = 1'b1;
                else owner = -1;
            end else begin
                tenure++;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (m_live) begin
            eg = (owner >= 0) ? (N'(1) << owner) : '0;
            check("gnt",       32'(gnt),             32'(eg));
            check("gnt_idx",   32'(gidx),            (owner >= 0) ? 32'(owner) : 32'd0);
            check("gnt_valid", 32'(gvalid),          32'(owner >= 0));
            check("revoke",    32'(revoke),          32'(drain));
            check("timeout",   32'(tmo),             32'(m_tmo));
            check("onehot0",   32'($onehot0(gnt)),   32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int hi, t, rv, k, dead;
        int held [N];
        int seq[$];
        int deads[$];
        int exp_seq [4];
        logic [N-1:0] prev, nreq;
        exp_seq = '{0, 1, 2, 0};

        // 1: reset with all requesting, then first grant goes to master 0
        rst = 1'b1; req = 3'b111;
        step();
        check("rst_gnt", 32'(gnt), 32'd0);
        step();
        check("rst_valid", 32'(gvalid), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_gnt", 32'(gnt), 32'b001);
        req = '0;
        repeat (2) step();

        // 2: single requester 2, drop at cycle 5
        req = 3'b100;
        step();
        check("s2_gnt", 32'(gnt), 32'b100);
        check("s2_idx", 32'(gidx), 32'd2);
        t = 0;
        repeat (4) begin step(); t += int'(tmo); end
        req = '0;
        step();
        t += int'(tmo);
        check("s2_release", 32'(gnt), 32'd0);
        check("s2_no_tmo", 32'(t), 32'd0);
        repeat (2) step();

        // 3: everyone requests, each drops 3 cycles into its tenancy
        req = 3'b111; prev = '0; dead = 0;
        for (int i = 0; i < N; i++) held[i] = 0;
        repeat (16) begin
            step();
            if (gnt == '0) dead++;
            else begin
                if (prev == '0) begin seq.push_back(int'(gidx)); deads.push_back(dead); end
                dead = 0;
            end
            prev = gnt;
            nreq = '0;
            for (int i = 0; i < N; i++) begin
                if (bitof(gnt, i)) begin
                    held[i]++;
                    if (held[i] < 3) nreq = nreq | (N'(1) << i);
                end else begin
                    held[i] = 0;
                    nreq = nreq | (N'(1) << i);
                end
            end
            req = nreq;
        end
        for (int i = 0; i < 4; i++)
            check("s3_rr_seq", (i < seq.size()) ? 32'(seq[i]) : 32'd99, 32'(exp_seq[i]));
        for (int i = 1; i < 4; i++)
            check("s3_dead", (i < deads.size()) ? 32'(deads[i]) : 32'd99, 32'd1);
        req = '0;
        repeat (3) step();

        // 4: master 1 holds past the limit, master 0 waiting
        req = 3'b010;
        step();
        check("s4_gnt", 32'(gnt), 32'b010);
        req = 3'b011; hi = 1; t = 0; k = 0;
        while (k < 40) begin
            step(); k++;
            t += int'(tmo);
            if (gnt == 3'b010) hi++;
            else break;
        end
        check("s4_hold_len", 32'(hi), 32'd8);
        check("s4_tmo_cnt", 32'(t), 32'd1);
        step();
        check("s4_next_owner", 32'(gnt), 32'b001);
        req = '0;
        repeat (3) step();

        // 5: timeout while busy, drain until busy drops
        req = 3'b010; busy = 1'b0;
        step();
        k = 1; hi = (gnt == 3'b010) ? 1 : 0; rv = 0; t = 0;
        busy = (k >= 6 && k <= 11);
        while (k < 40) begin
            step(); k++;
            rv += int'(revoke);
            t  += int'(tmo);
            if (gnt == 3'b010) hi++;
            else break;
            busy = (k >= 6 && k <= 11);
        end
        req = '0; busy = 1'b0;
        check("s5_hold_len", 32'(hi), 32'd12);
        check("s5_revoke_cnt", 32'(rv), 32'd4);
        check("s5_tmo_cnt", 32'(t), 32'd1);
        repeat (3) step();

        // 6: locked owner keeps grant for 40 cycles, unlock forces release
        req = 3'b010; lock = 3'b010;
        step();
        hi = (gnt == 3'b010) ? 1 : 0; t = 0;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (gnt == 3'b010) hi++;
            t += int'(tmo);
        end
        check("s6_locked_len", 32'(hi), 32'd40);
        check("s6_no_tmo", 32'(t), 32'd0);
        lock = '0;
        step();
        check("s6_release", 32'(gnt), 32'd0);
        check("s6_tmo", 32'(tmo), 32'd1);
        req = '0;
        repeat (2) step();

        // Random traffic with occasional reset, checked against the model
        repeat (4000) begin
            step();
            rst = (!rst && $urandom_range(299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0)  req  = req  ^ (N'(1) << i);
                if ($urandom_range(15) == 0) lock = lock ^ (N'(1) << i);
            end
            busy = ($urandom_range(2) == 0);
        end
        rst = 1'b0; req = '0; lock = '0; busy = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
